// File: rtl/mux_3_rr_arb_if.sv
// Handshake bundle between three requesters, the round-robin arbiter and the
// downstream consumer of the registered 3:1 output.
interface mux_3_rr_arb_if #(
  parameter int K = 8
);
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [K-1:0] a0;
  logic [K-1:0] a1;
  logic [K-1:0] a2;
  logic [2:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] out_data;
  logic [1:0]   out_src;

  modport slave (
    input  in_valid, a0, a1, a2, out_ready,
    output in_ready, sel, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, a0, a1, a2, out_ready,
    input  in_ready, sel, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux_3_rr_arb.sv
// Round-robin arbiter plus registered output stage for a shared 3:1 K-bit channel.
// Optional per-requester grant counters are built when MUX3_ARB_GRANT_CNT_EN is defined.
module mux_3_rr_arb #(
  parameter int K  = 8,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
`ifdef MUX3_ARB_GRANT_CNT_EN
  input  logic                cnt_clr,
  output logic [CW-1:0]       cnt0,
  output logic [CW-1:0]       cnt1,
  output logic [CW-1:0]       cnt2,
`endif
  mux_3_rr_arb_if.slave       bus
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e       state_q;
  logic [2:0]   last_q;
  logic [K-1:0] out_data_q;
  logic [1:0]   out_src_q;

  logic [1:0]   win_idx;
  logic [2:0]   win_oh;
  logic [K-1:0] win_data;
  logic         load;
  logic [2:0]   sel_w;

  // Search order starts just after the previous winner.
  always_comb begin
    win_idx = 2'd0;
    case (last_q)
      3'b001: begin
        if      (bus.in_valid[1]) win_idx = 2'd1;
        else if (bus.in_valid[2]) win_idx = 2'd2;
        else                      win_idx = 2'd0;
      end
      3'b010: begin
        if      (bus.in_valid[2]) win_idx = 2'd2;
        else if (bus.in_valid[0]) win_idx = 2'd0;
        else                      win_idx = 2'd1;
      end
      default: begin
        if      (bus.in_valid[0]) win_idx = 2'd0;
        else if (bus.in_valid[1]) win_idx = 2'd1;
        else                      win_idx = 2'd2;
      end
    endcase
  end

  always_comb begin
    win_oh = 3'b000;
    win_oh[win_idx] = 1'b1;
  end

  always_comb begin
    case (win_idx)
      2'd1:    win_data = bus.a1;
      2'd2:    win_data = bus.a2;
      default: win_data = bus.a0;
    endcase
  end

  // A reset cycle never completes an input handshake.
  assign load  = !rst && ((state_q == EMPTY) || bus.out_ready) && (|bus.in_valid);
  assign sel_w = load ? win_oh : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      last_q     <= 3'b100;
      out_data_q <= '0;
      out_src_q  <= 2'd0;
    end else if (load) begin
      state_q    <= FULL;
      last_q     <= win_oh;
      out_data_q <= win_data;
      out_src_q  <= win_idx;
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_q    <= EMPTY;
    end
  end

  assign bus.sel       = sel_w;
  assign bus.in_ready  = sel_w;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

`ifdef MUX3_ARB_GRANT_CNT_EN
  logic [CW-1:0] cnt_q [3];

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sel_w[i]) cnt_q[i] <= cnt_q[i] + CW'(1);
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
`endif

endmodule

// File: tb/tb_mux_3_rr_arb.sv
// Self-checking bench for mux_3_rr_arb: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_mux_3_rr_arb;
  localparam int K  = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef MUX3_ARB_GRANT_CNT_EN
  logic          cnt_clr = 1'b0;
  logic          clr_next = 1'b0;
  logic [CW-1:0] cnt0, cnt1, cnt2;
`endif

  mux_3_rr_arb_if #(.K(K)) bus ();

  mux_3_rr_arb #(.K(K), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef MUX3_ARB_GRANT_CNT_EN
    .cnt_clr (cnt_clr),
    .cnt0    (cnt0),
    .cnt1    (cnt1),
    .cnt2    (cnt2),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: output slot contents and index of the last winner.
  logic         m_valid = 1'b0;
  logic [K-1:0] m_data  = '0;
  int           m_src   = 0;
  int           m_last  = 2;
  int           m_cnt [3] = '{0, 0, 0};

  // Inputs change at the falling edge; everything is compared 2 time units later
  // and the model then advances to what the next rising edge must produce.
  always @(negedge clk) begin
    int           w;
    bit           ld;
    logic [2:0]   exp_sel;
    logic [K-1:0] ad [3];
    #2;
    w = -1;
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (m_last + k) % 3;
      if (w < 0 && bus.in_valid[idx]) w = idx;
    end
    ld = !rst && (!m_valid || bus.out_ready) && (w >= 0);
    exp_sel = 3'b000;
    if (ld) exp_sel[w] = 1'b1;
    ad[0] = bus.a0; ad[1] = bus.a1; ad[2] = bus.a2;

    chk("sel",       32'(bus.sel),       32'(exp_sel));
    chk("in_ready",  32'(bus.in_ready),  32'(exp_sel));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_data",  32'(bus.out_data),  32'(m_data));
    chk("out_src",   32'(bus.out_src),   32'(m_src));
`ifdef MUX3_ARB_GRANT_CNT_EN
    chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
    chk("cnt1", 32'(cnt1), 32'(m_cnt[1]));
    chk("cnt2", 32'(cnt2), 32'(m_cnt[2]));
    if (rst || cnt_clr) m_cnt = '{0, 0, 0};
    else if (ld) m_cnt[w] = (m_cnt[w] + 1) % (1 << CW);
`endif

    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_src = 0; m_last = 2;
    end else if (ld) begin
      m_valid = 1'b1; m_data = ad[w]; m_src = w; m_last = w;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic drive(input logic r, input logic [2:0] iv, input logic [K-1:0] d0,
                       input logic [K-1:0] d1, input logic [K-1:0] d2, input logic ordy);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = iv;
    bus.a0        = d0;
    bus.a1        = d1;
    bus.a2        = d2;
    bus.out_ready = ordy;
`ifdef MUX3_ARB_GRANT_CNT_EN
    cnt_clr       = clr_next;
`endif
    #3;
  endtask

  logic [2:0]   sel_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [K-1:0] dat_seq [6] = '{8'h10, 8'h21, 8'h32, 8'h10, 8'h21, 8'h32};

  initial begin
    bus.in_valid  = 3'b111;
    bus.a0        = '0;
    bus.a1        = '0;
    bus.a2        = '0;
    bus.out_ready = 1'b1;

    repeat (2) begin
      drive(1'b1, 3'b111, 8'h10, 8'h21, 8'h32, 1'b1);
      chk("rst_sel",   32'(bus.sel),       32'h0);
      chk("rst_ready", 32'(bus.in_ready),  32'h0);
      chk("rst_valid", 32'(bus.out_valid), 32'h0);
    end

    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 3'b111, 8'h10, 8'h21, 8'h32, 1'b1);
      chk("rot_sel", 32'(bus.sel), 32'(sel_seq[i]));
      if (i > 0) begin
        chk("rot_data", 32'(bus.out_data), 32'(dat_seq[i-1]));
        chk("rot_src",  32'(bus.out_src),  32'((i - 1) % 3));
      end
    end

    drive(1'b0, 3'b010, 8'h10, 8'h5A, 8'h32, 1'b1);
    chk("cap_sel",  32'(bus.sel),      32'h2);
    chk("cap_prev", 32'(bus.out_data), 32'h32);
    repeat (4) begin
      drive(1'b0, 3'b101, 8'h10, 8'h66, 8'h32, 1'b0);
      chk("bp_data",  32'(bus.out_data), 32'h5A);
      chk("bp_src",   32'(bus.out_src),  32'h1);
      chk("bp_ready", 32'(bus.in_ready), 32'h0);
    end
    drive(1'b0, 3'b101, 8'h10, 8'h66, 8'h32, 1'b1);
    chk("bp_next", 32'(bus.sel), 32'h4);

    repeat (3) begin
      drive(1'b0, 3'b010, 8'h10, 8'h44, 8'h32, 1'b1);
      chk("single_ready", 32'(bus.in_ready),  32'h2);
      chk("single_valid", 32'(bus.out_valid), 32'h1);
    end

    drive(1'b0, 3'b001, 8'h77, 8'h44, 8'h32, 1'b1);
    chk("drain_sel", 32'(bus.sel), 32'h1);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("drain_v1", 32'(bus.out_valid), 32'h1);
    chk("drain_d1", 32'(bus.out_data),  32'h77);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("drain_v0", 32'(bus.out_valid), 32'h0);
    chk("drain_d0", 32'(bus.out_data),  32'h77);

    for (int n = 0; n < 3000; n++) begin
`ifdef MUX3_ARB_GRANT_CNT_EN
      clr_next = ($urandom_range(0, 31) == 0);
`endif
      drive(($urandom_range(0, 63) == 0), 3'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_3_rr_arb.md
Name: mux_3_rr_arb

Overview:
- Round-robin arbiter and output register for a shared 3-to-1, K-bit channel.
- Three requesters present data with valid/ready handshakes.
- The arbiter picks one requester, drives a one-hot select (3'b001/010/100), and captures the selected data into a registered output stage with a valid/ready handshake.
- Sits in front of the team's one-hot 3:1 mux and owns its select sequencing.

Parameters:
K, 8, data width of each requester and of the output.
CW, 16, width of each grant counter (used only with the optional feature).

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  3  per-requester valid; bit i belongs to requester i.
in_ready  output  3  per-requester accept; at most one bit high per cycle.
a0  input  K  requester 0 data.
a1  input  K  requester 1 data.
a2  input  K  requester 2 data.
sel  output  3  one-hot select of the current grant; 3'b000 when no grant.
out_valid  output  1  output register holds data.
out_ready  input  1  downstream accept.
out_data  output  K  registered selected data.
out_src  output  2  index (0..2) of the requester that owns out_data.

Behaviour:
Reset:
- Applied on the clk edge while rst=1.
- out_valid=0, out_data=0, out_src=0, sel=3'b000, in_ready=3'b000.
- Round-robin pointer last=3'b100, so requester 0 has first priority.
- rst asserted mid-transfer discards held data; no in_ready is issued in that cycle.

Load condition:
- load = (!out_valid || out_ready) && |in_valid.
- When load=1, the output slot is free or is being freed this cycle.

Arbitration (combinational from in_valid and last):
- Priority order starts after the last granted requester:
  - last=001 -> order 1,2,0.
  - last=010 -> order 2,0,1.
  - last=100 -> order 0,1,2.
- Winner w is the first requester in that order with in_valid set.

Outputs derived from load:
- sel = onehot(w) when load=1, else 3'b000.
- in_ready = sel. The handshake completes in the same cycle, and the requester may drop or change data on the next cycle.

On a clk edge with load=1:
- out_data <= selected a_w; out_src <= w; out_valid <= 1; last <= onehot(w).

On a clk edge with out_valid && out_ready && !|in_valid:
- out_valid <= 0; out_data and out_src keep their values.

Throughput and latency:
- Back-to-back: a downstream accept and a new capture may happen in the same cycle, giving 1 transfer per cycle at full throughput.
- Latency from in_valid&in_ready to out_valid is 1 cycle.

Backpressure:
- While out_valid=1 and out_ready=0, in_ready=0 and out_data/out_src are held stable.

Fairness:
- With all three requesters continuously valid, grants rotate 0,1,2,0,...
- No requester waits more than 2 grants once it is valid.
- A single requester valid on its own is granted every available cycle.

Requester behaviour:
- Requesters may deassert in_valid before being granted; they are not required to hold it.
- The arbiter samples in_valid only in the cycle where load=1.

FSM (implicit, two states): EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY -> FULL on load.
- FULL -> FULL on load, or while out_ready=0.
- FULL -> EMPTY on out_ready with no in_valid.

Optional Feature:
MUX3_ARB_GRANT_CNT_EN
- Defined:
  - Adds outputs cnt0, cnt1, cnt2, each CW bits.
  - cnt_i increments on every clk edge where in_ready[i]=1 and wraps from 2^CW-1 to 0.
  - Counters reset to 0.
  - Adds input cnt_clr (1 bit), which zeroes all counters synchronously. When cnt_clr coincides with a grant, the counter ends at 0.
- Undefined: no counter ports or logic; all other behaviour is identical.

Test Plan:
- Reset, K=8: hold rst 2 cycles with in_valid=3'b111 -> out_valid=0, sel=000, in_ready=000 throughout; after release, first grant goes to requester 0.
- Rotation: a0=8'h10, a1=8'h21, a2=8'h32, in_valid=111, out_ready=1 for 6 cycles -> sel sequence 001,010,100,001,010,100; out_data one cycle later is 10,21,32,10,21,32; out_src is 0,1,2,0,1,2.
- Backpressure: capture a1=8'h5A, then out_ready=0 for 4 cycles with in_valid=101 -> out_data=5A and out_src=1 held, in_ready=000; on out_ready=1 the next grant is requester 2 (last=010).
- Single requester: only in_valid[1]=1 for 3 cycles with out_ready=1 -> in_ready=010 each cycle, out_valid high continuously, no bubbles.
- Drain: one transfer from requester 0, then in_valid=000 and out_ready=1 -> out_valid falls after one cycle; out_data stays at its last value.
- Counters (MUX3_ARB_GRANT_CNT_EN, CW=2): give requester 0 five grants -> cnt0 = 1,2,3,0,1. Pulse cnt_clr during a grant -> cnt0=0.
